// File: rtl/instr_encoder_if.sv
// Request/write bundle for instr_encoder: decoded-field request handshake on one
// side, instruction-memory write port plus status flags on the other.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        done;
   logic        err;

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      input  mem_ready,
      output in_ready, mem_write, mem_addr, mem_wdata, done, err
   );

   modport master (
      output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      output mem_ready,
      input  in_ready, mem_write, mem_addr, mem_wdata, done, err
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into R/I/S/B/J words and streams them through a
// small FIFO into instruction memory at sequential word addresses.
module instr_encoder #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input logic             clk,
   input logic             reset,
   instr_encoder_if.slave  bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;
   localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;

   logic [31:0]      fifo_q [FIFO_DEPTH];
   logic [31:0]      fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             ecall_seen_q, ecall_seen_d;

   logic [31:0] enc_word_s;
   logic        enc_ok_s;
   logic        i_fits_s, b_fits_s, j_fits_s;
   logic        full_s, empty_s, in_ready_s, accept_s, push_s, pop_s;
   logic [31:0] head_s;

   // Encoder: build the instruction word and decide whether the request is legal.
   always_comb begin
      enc_word_s = 32'h0000_0000;
      enc_ok_s   = 1'b0;
      i_fits_s   = (bus.in_imm == {{20{bus.in_imm[11]}}, bus.in_imm[11:0]});
      b_fits_s   = (bus.in_imm == {{19{bus.in_imm[12]}}, bus.in_imm[12:0]}) && !bus.in_imm[0];
      j_fits_s   = (bus.in_imm == {{11{bus.in_imm[20]}}, bus.in_imm[20:0]}) && !bus.in_imm[0];
      case (bus.in_opcode)
         OP_ARITH: begin
            enc_word_s = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            enc_ok_s   = 1'b1;
         end
         OP_ARITH_IMM, OP_LOAD, OP_JALR: begin
            if ((bus.in_opcode == OP_ARITH_IMM) &&
                ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101))) begin
               enc_word_s = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                             bus.in_rd, bus.in_opcode};
            end else begin
               enc_word_s = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            enc_ok_s = i_fits_s;
         end
         OP_STORE: begin
            enc_word_s = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_imm[4:0], bus.in_opcode};
            enc_ok_s   = i_fits_s;
         end
         OP_BRANCH: begin
            enc_word_s = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
            enc_ok_s   = b_fits_s;
         end
         OP_JAL: begin
            enc_word_s = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                          bus.in_rd, bus.in_opcode};
            enc_ok_s   = j_fits_s;
         end
         OP_ECALL: begin
            enc_word_s = ECALL_WORD;
            enc_ok_s   = 1'b1;
         end
         default: begin
            enc_word_s = 32'h0000_0000;
            enc_ok_s   = 1'b0;
         end
      endcase
   end

   assign full_s     = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty_s    = (count_q == {CNT_W{1'b0}});
   assign head_s     = fifo_q[rd_ptr_q];
   // Accepting an ECALL closes the input at once, before its word has drained.
   assign in_ready_s = !reset && !full_s && !done_q && !ecall_seen_q;
   assign accept_s   = bus.in_valid && in_ready_s;
   assign push_s     = accept_s && enc_ok_s;
   assign pop_s      = !empty_s && bus.mem_ready;

   // Next-state logic for FIFO, write address and sticky status flags.
   always_comb begin
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      mem_addr_d   = mem_addr_q;
      if (push_s) begin
         fifo_d[wr_ptr_q] = enc_word_s;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         mem_addr_d = mem_addr_q + 32'd4;
      end else begin
         rd_ptr_d   = rd_ptr_q;
         mem_addr_d = mem_addr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      err_d        = err_q || (accept_s && !enc_ok_s);
      ecall_seen_d = ecall_seen_q || (accept_s && (bus.in_opcode == OP_ECALL));
      done_d       = done_q || (pop_s && (head_s == ECALL_WORD));
   end

   // State registers with synchronous reset; reset discards all queued words.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= 32'h0000_0000;
         end
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         mem_addr_q   <= BASE_ADDR;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         ecall_seen_q <= 1'b0;
      end else begin
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         mem_addr_q   <= mem_addr_d;
         done_q       <= done_d;
         err_q        <= err_d;
         ecall_seen_q <= ecall_seen_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.mem_write = !empty_s;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = head_s;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios plus randomized requests
// checked against an arithmetic reference encoder.
module tb_instr_encoder;
   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rnd_mode = 1'b0;
   logic dir_ready = 1'b0;
   logic rnd_ready = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [63:0] sb [$];
   int unsigned exp_addr = 0;
   logic exp_err = 1'b0;
   logic prev_stall = 1'b0;
   logic [31:0] prev_addr = 32'h0, prev_data = 32'h0;

   int bnd [12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098,
                    1048574, -1048576, 1048576, 3};
   logic [6:0] ops [8] = '{OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_JALR,
                           OP_STORE, OP_BRANCH, OP_JAL, 7'b0110111};

   instr_encoder_if bus ();
   instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   assign bus.mem_ready = rnd_mode ? rnd_ready : dir_ready;
   always @(posedge clk) begin
      #1 rnd_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference encoder: returns {ok, word}, built from field positions by arithmetic.
   function automatic logic [32:0] ref_encode(input logic [6:0] op, input int rd, input int rs1,
                                              input int rs2, input int f3, input int f7, input int imm);
      int unsigned w = 0;
      bit ok = 0;
      int unsigned base = (rs1 << 15) | (f3 << 12) | op;
      case (op)
         OP_ARITH: begin ok = 1; w = (f7 << 25) | (rs2 << 20) | base | (rd << 7); end
         OP_ARITH_IMM, OP_LOAD, OP_JALR: begin
            ok = (imm >= -2048) && (imm <= 2047);
            if (op == OP_ARITH_IMM && (f3 == 1 || f3 == 5))
               w = (f7 << 25) | ((imm & 31) << 20) | base | (rd << 7);
            else
               w = ((imm & 4095) << 20) | base | (rd << 7);
         end
         OP_STORE: begin
            ok = (imm >= -2048) && (imm <= 2047);
            w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | base | ((imm & 31) << 7);
         end
         OP_BRANCH: begin
            ok = (imm >= -4096) && (imm <= 4094) && ((imm % 2) == 0);
            w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | base |
                (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
         end
         OP_JAL: begin
            ok = (imm >= -1048576) && (imm <= 1048574) && ((imm % 2) == 0);
            w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20) |
                (((imm >> 12) & 255) << 12) | (rd << 7) | op;
         end
         OP_ECALL: begin ok = 1; w = 32'h73; end
         default: begin ok = 0; w = 0; end
      endcase
      return {ok, w};
   endfunction

   task automatic send(input logic [6:0] op, input int rd, input int rs1, input int rs2,
                       input int f3, input int f7, input int imm);
      logic [32:0] r;
      bit got = 0;
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_rd     = 5'(rd);
      bus.in_rs1    = 5'(rs1);
      bus.in_rs2    = 5'(rs2);
      bus.in_funct3 = 3'(f3);
      bus.in_funct7 = 7'(f7);
      bus.in_imm    = 32'(imm);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin got = 1; break; end
      end
      if (!got) begin
         chk("send_timeout", 32'(bus.in_ready), 32'h1);
      end else begin
         r = ref_encode(op, rd, rs1, rs2, f3, f7, imm);
         if (r[32]) begin
            sb.push_back({exp_addr, r[31:0]});
            exp_addr += 4;
         end else begin
            exp_err = 1'b1;
         end
         @(posedge clk);
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("in_ready_in_reset", 32'(bus.in_ready), 32'h0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      sb.delete();
      exp_addr = 0;
      exp_err  = 1'b0;
      @(negedge clk);
      chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #2;
         if (sb.size() == 0 && !bus.mem_write) begin ok = 1; break; end
      end
      chk("drain", 32'(ok), 32'h1);
   endtask

   // Monitor: pop expected writes and check stall stability.
   always @(negedge clk) begin
      logic [63:0] e;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_addr_stable", bus.mem_addr, prev_addr);
            chk("stall_data_stable", bus.mem_wdata, prev_data);
         end
         if (bus.mem_write && bus.mem_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("wr_addr", bus.mem_addr, e[63:32]);
               chk("wr_data", bus.mem_wdata, e[31:0]);
            end
         end
         prev_stall = bus.mem_write && !bus.mem_ready;
         prev_addr  = bus.mem_addr;
         prev_data  = bus.mem_wdata;
      end
   end

   initial begin
      bit seen;
      bus.in_valid = 1'b0; bus.in_opcode = 7'h0; bus.in_rd = 5'h0; bus.in_rs1 = 5'h0;
      bus.in_rs2 = 5'h0; bus.in_funct3 = 3'h0; bus.in_funct7 = 7'h0; bus.in_imm = 32'h0;
      do_reset();

      // add x3,x1,x2 with latency-1 write
      dir_ready = 1'b1;
      send(OP_ARITH, 3, 1, 2, 0, 0, 0);
      @(negedge clk);
      chk("t1_latency_write", 32'(bus.mem_write), 32'h1);
      chk("t1_data", bus.mem_wdata, 32'h002081B3);
      drain();

      // addi x5,x0,-1 ; sw x2,8(x1)
      do_reset();
      dir_ready = 1'b0;
      send(OP_ARITH_IMM, 5, 0, 0, 0, 0, -1);
      send(OP_STORE, 0, 1, 2, 2, 0, 8);
      @(negedge clk);
      chk("t2_head", bus.mem_wdata, 32'hFFF00293);
      dir_ready = 1'b1;
      drain();

      // beq legal then two illegal offsets
      do_reset();
      dir_ready = 1'b0;
      send(OP_BRANCH, 0, 1, 2, 0, 0, -4);
      @(negedge clk);
      chk("t3_beq", bus.mem_wdata, 32'hFE208EE3);
      dir_ready = 1'b1;
      drain();
      send(OP_BRANCH, 0, 1, 2, 0, 0, -3);
      drain();
      chk("t3_err_odd", 32'(bus.err), 32'(exp_err));
      do_reset();
      send(OP_BRANCH, 0, 1, 2, 0, 0, 4096);
      drain();
      chk("t3_err_range", 32'(bus.err), 32'h1);
      chk("t3_addr_unchanged", bus.mem_addr, 32'h0);

      // fill FIFO while memory stalls, then release
      do_reset();
      dir_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(OP_ARITH, i + 1, i, i + 2, 0, 0, 0);
      @(negedge clk);
      chk("t4_full_in_ready", 32'(bus.in_ready), 32'h0);
      chk("t4_full_addr", bus.mem_addr, 32'h0);
      fork
         send(OP_ARITH, 9, 8, 7, 7, 32, 0);
         begin repeat (3) @(posedge clk); #1 dir_ready = 1'b1; end
      join
      drain();
      chk("t4_end_addr", bus.mem_addr, 32'd20);

      // out-of-range addi rejected, next one lands at address 0
      do_reset();
      send(OP_ARITH_IMM, 1, 0, 0, 0, 0, 2048);
      send(OP_ARITH_IMM, 1, 0, 0, 0, 0, 1);
      drain();
      chk("t5_err", 32'(bus.err), 32'h1);
      chk("t5_addr", bus.mem_addr, 32'd4);

      // ECALL closes input and raises done once written
      do_reset();
      send(OP_ECALL, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t6_in_ready_drop", 32'(bus.in_ready), 32'h0);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.done) begin seen = 1; break; end
      end
      chk("t6_done", 32'(seen), 32'h1);
      chk("t6_in_ready_after", 32'(bus.in_ready), 32'h0);

      // reset mid-stream discards queued words
      do_reset();
      dir_ready = 1'b0;
      send(OP_ARITH, 1, 2, 3, 0, 0, 0);
      send(OP_ARITH, 4, 5, 6, 0, 0, 0);
      do_reset();
      dir_ready = 1'b1;

      // randomized requests with random memory back-pressure
      rnd_mode = 1'b1;
      for (int n = 0; n < 80; n++) begin
         int imm;
         case ($urandom_range(0, 3))
            0:       imm = int'($urandom_range(0, 4095)) - 2048;
            1:       imm = bnd[$urandom_range(0, 11)];
            2:       imm = int'($urandom_range(0, 2097151)) - 1048576;
            default: imm = int'($urandom);
         endcase
         send(ops[$urandom_range(0, 7)], int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 127)), imm);
      end
      drain();
      rnd_mode = 1'b0;
      @(negedge clk);
      chk("rnd_err", 32'(bus.err), 32'(exp_err));
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
